// File: rtl/add_share_pkg.sv
// Shared types, defaults and the round-robin pick function for add_share_ctrl.
package add_share_pkg;

   localparam int WIDTH_DEF   = 16;
   localparam int NUM_REQ_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // First requester at or after last+1 (modulo n) with its request bit set.
   // The search walks k from far to near so the nearest hit is written last.
   // Returns 0 when nothing is requesting; callers qualify with |req.
   function automatic int rr_winner(input logic [7:0] req, input int last, input int n);
      int win;
      int idx;
      win = 0;
      for (int k = n; k >= 1; k--) begin
         idx = (last + k) % n;
         if (req[idx]) win = idx;
      end
      return win;
   endfunction

endpackage

// File: rtl/add_share_adder.sv
// The single shared adder: unsigned, carry kept in the top sum bit.
module add_share_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH:0]   o_sum
);

   assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/add_share_rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus winner index, gated by enable.
module rr_arbiter
   import add_share_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last_grant,
   input  logic               i_enable,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_win
);

   logic            w_any;
   logic [ID_W-1:0] w_win;

   assign w_any   = |i_req;
   assign w_win   = ID_W'(rr_winner(8'(i_req), int'(i_last_grant), NUM_REQ));
   assign o_win   = w_win;
   assign o_grant = (i_enable && w_any) ? (NUM_REQ'(1) << w_win) : '0;

endmodule

// File: rtl/add_share_ctrl.sv
// Shares one adder between NUM_REQ valid/ready requesters, round-robin,
// with a single registered response channel tagged by requester ID.
module add_share_ctrl
   import add_share_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req_valid,
   input  logic [NUM_REQ*WIDTH-1:0] req_a,
   input  logic [NUM_REQ*WIDTH-1:0] req_b,
   output logic [NUM_REQ-1:0]       req_ready,
   output logic                     resp_valid,
   output logic [WIDTH:0]           resp_sum,
   output logic [ID_W-1:0]          resp_id,
   input  logic                     resp_ready,
   output logic                     busy,
   output logic [15:0]              op_count
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_op_a;
   logic [WIDTH-1:0]   r_op_b;
   logic [ID_W-1:0]    r_op_id;
   logic [ID_W-1:0]    r_last_grant;
   logic [WIDTH:0]     r_sum;
   logic [ID_W-1:0]    r_resp_id;
   logic               r_resp_valid;
   logic [15:0]        r_op_count;

   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_win;
   logic               w_take;
   logic [WIDTH:0]     w_sum;

   // Grants only while idle, so req_ready is zero in EXEC/HOLD.
   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .i_req        (req_valid),
      .i_last_grant (r_last_grant),
      .i_enable     (r_state == IDLE),
      .o_grant      (w_grant),
      .o_win        (w_win)
   );

   add_share_adder #(.WIDTH(WIDTH)) u_add (
      .i_a   (r_op_a),
      .i_b   (r_op_b),
      .o_sum (w_sum)
   );

   // grant is only raised on a valid request, so any grant bit is a handshake
   assign w_take = |w_grant;

   // Control FSM: capture on grant, add in EXEC, hold result until accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_id      <= '0;
         r_last_grant <= ID_W'(NUM_REQ - 1);
         r_sum        <= '0;
         r_resp_id    <= '0;
         r_resp_valid <= 1'b0;
         r_op_count   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_take) begin
                  r_op_a       <= req_a[w_win*WIDTH +: WIDTH];
                  r_op_b       <= req_b[w_win*WIDTH +: WIDTH];
                  r_op_id      <= w_win;
                  r_last_grant <= w_win;
                  r_state      <= EXEC;
               end
            end
            EXEC: begin
               r_sum        <= w_sum;
               r_resp_id    <= r_op_id;
               r_resp_valid <= 1'b1;
               r_state      <= HOLD;
            end
            HOLD: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_op_count   <= r_op_count + 16'd1;
                  r_state      <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = w_grant;
   assign resp_valid = r_resp_valid;
   assign resp_sum   = r_sum;
   assign resp_id    = r_resp_id;
   assign busy       = (r_state != IDLE);
   assign op_count   = r_op_count;

endmodule

// File: tb/tb_add_share_ctrl.sv
// Directed bench for add_share_ctrl: inputs driven and outputs sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_add_share_ctrl;

   logic        clk;
   logic        rst;
   logic [3:0]  req_valid;
   logic [63:0] req_a;
   logic [63:0] req_b;
   logic [3:0]  req_ready;
   logic        resp_valid;
   logic [16:0] resp_sum;
   logic [1:0]  resp_id;
   logic        resp_ready;
   logic        busy;
   logic [15:0] op_count;

   int total = 0;
   int bad   = 0;

   add_share_ctrl #(.WIDTH(16), .NUM_REQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_sum   (resp_sum),
      .resp_id    (resp_id),
      .resp_ready (resp_ready),
      .busy       (busy),
      .op_count   (op_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #50000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic test_reset;
      rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL rst_req_ready got %b exp 0000", req_ready); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
      total++; if (resp_sum !== 17'h0) begin bad++; $display("FAIL rst_resp_sum got %h exp 0", resp_sum); end
      total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL rst_resp_id got %0d exp 0", resp_id); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b exp 0", busy); end
      total++; if (op_count !== 16'h0) begin bad++; $display("FAIL rst_op_count got %h exp 0", op_count); end
      rst = 1'b0;
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_single;
      req_a[2*16 +: 16] = 16'h1234; req_b[2*16 +: 16] = 16'h0FFF;
      req_valid = 4'b0100; resp_ready = 1'b1;
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got %b exp 0100", req_ready); end
      @(negedge clk);
      req_valid = 4'b0000;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_exec_ready got %b exp 0000", req_ready); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_exec_busy got %b exp 1", busy); end
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_exec_valid got %b exp 0", resp_valid); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b exp 1", resp_valid); end
      total++; if (resp_sum !== 17'h02233) begin bad++; $display("FAIL single_sum got %h exp 02233", resp_sum); end
      total++; if (resp_id !== 2'd2) begin bad++; $display("FAIL single_id got %0d exp 2", resp_id); end
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL single_drop got %b exp 0", resp_valid); end
      total++; if (op_count !== 16'd1) begin bad++; $display("FAIL single_count got %0d exp 1", op_count); end
      total++; if (resp_sum !== 17'h02233) begin bad++; $display("FAIL single_sum_kept got %h exp 02233", resp_sum); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle_busy got %b exp 0", busy); end
   endtask

   task automatic test_carry;
      req_a[0 +: 16] = 16'hFFFF; req_b[0 +: 16] = 16'hFFFF;
      req_valid = 4'b0001; resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      total++; if (resp_sum !== 17'h1FFFE) begin bad++; $display("FAIL carry_sum got %h exp 1fffe", resp_sum); end
      total++; if (resp_sum[16] !== 1'b1) begin bad++; $display("FAIL carry_bit got %b exp 1", resp_sum[16]); end
      total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL carry_id got %0d exp 0", resp_id); end
      @(negedge clk);
      total++; if (op_count !== 16'd2) begin bad++; $display("FAIL carry_count got %0d exp 2", op_count); end
   endtask

   task automatic test_async_reset;
      req_a[3*16 +: 16] = 16'h0005; req_b[3*16 +: 16] = 16'h0006;
      req_valid = 4'b1000; resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      total++; if (resp_valid !== 1'b1 || resp_sum !== 17'h0000B || resp_id !== 2'd3) begin
         bad++; $display("FAIL areset_pre got v=%b s=%h id=%0d exp v=1 s=0000b id=3", resp_valid, resp_sum, resp_id);
      end
      #2 rst = 1'b1;
      #1;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL areset_valid got %b exp 0", resp_valid); end
      total++; if (resp_sum !== 17'h0) begin bad++; $display("FAIL areset_sum got %h exp 0", resp_sum); end
      total++; if (resp_id !== 2'd0) begin bad++; $display("FAIL areset_id got %0d exp 0", resp_id); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL areset_busy got %b exp 0", busy); end
      total++; if (op_count !== 16'h0) begin bad++; $display("FAIL areset_count got %h exp 0", op_count); end
      total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL areset_ready got %b exp 0000", req_ready); end
      @(negedge clk);
      rst = 1'b0; resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL areset_replay got v=%b busy=%b exp v=0 busy=0", resp_valid, busy);
      end
   endtask

   task automatic test_fairness;
      logic [15:0] a_tab [4];
      logic [15:0] b_tab [4];
      logic [16:0] s_tab [4];
      logic [3:0]  onehot;
      int          exp_id;
      a_tab = '{16'h0001, 16'h8000, 16'hABCD, 16'hFFFF};
      b_tab = '{16'h0002, 16'h8000, 16'h1234, 16'h0010};
      s_tab = '{17'h00003, 17'h10000, 17'h0BE01, 17'h1000F};
      for (int i = 0; i < 4; i++) begin
         req_a[i*16 +: 16] = a_tab[i];
         req_b[i*16 +: 16] = b_tab[i];
      end
      req_valid = 4'b1111; resp_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         exp_id = k % 4;
         onehot = 4'b0001 << exp_id;
         #1;
         total++; if (req_ready !== onehot) begin bad++; $display("FAIL fair_grant[%0d] got %b exp %b", k, req_ready, onehot); end
         @(negedge clk);
         @(negedge clk);
         total++; if (resp_valid !== 1'b1 || resp_id !== 2'(exp_id) || resp_sum !== s_tab[exp_id]) begin
            bad++; $display("FAIL fair_resp[%0d] got v=%b id=%0d s=%h exp v=1 id=%0d s=%h",
                            k, resp_valid, resp_id, resp_sum, exp_id, s_tab[exp_id]);
         end
         @(negedge clk);
      end
      req_valid = 4'b0000;
      total++; if (op_count !== 16'd8) begin bad++; $display("FAIL fair_count got %0d exp 8", op_count); end
   endtask

   task automatic test_backpressure;
      req_a[0 +: 16] = 16'h0100; req_b[0 +: 16] = 16'h0200;
      req_a[16 +: 16] = 16'h7FFF; req_b[16 +: 16] = 16'h8001;
      req_valid = 4'b0011; resp_ready = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL bp_grant0 got %b exp 0001", req_ready); end
      @(negedge clk);
      req_a[0 +: 16] = 16'hDEAD;
      @(negedge clk);
      for (int c = 0; c < 5; c++) begin
         total++; if (resp_valid !== 1'b1 || resp_sum !== 17'h00300 || resp_id !== 2'd0 || req_ready !== 4'b0) begin
            bad++; $display("FAIL bp_hold[%0d] got v=%b s=%h id=%0d rdy=%b exp v=1 s=00300 id=0 rdy=0000",
                            c, resp_valid, resp_sum, resp_id, req_ready);
         end
         @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got %b exp 0", resp_valid); end
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_grant1 got %b exp 0010", req_ready); end
      total++; if (op_count !== 16'd9) begin bad++; $display("FAIL bp_count got %0d exp 9", op_count); end
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      total++; if (resp_sum !== 17'h10000 || resp_id !== 2'd1) begin
         bad++; $display("FAIL bp_second got s=%h id=%0d exp s=10000 id=1", resp_sum, resp_id);
      end
      @(negedge clk);
      total++; if (op_count !== 16'd10) begin bad++; $display("FAIL bp_count2 got %0d exp 10", op_count); end
   endtask

   task automatic test_wrap;
      force dut.r_op_count = 16'hFFFF;
      #1 release dut.r_op_count;
      total++; if (op_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_preload got %h exp ffff", op_count); end
      req_a[2*16 +: 16] = 16'h0001; req_b[2*16 +: 16] = 16'hFFFF;
      req_valid = 4'b0100; resp_ready = 1'b1;
      @(negedge clk);
      req_valid = 4'b0000;
      @(negedge clk);
      total++; if (resp_sum !== 17'h10000 || resp_id !== 2'd2) begin
         bad++; $display("FAIL wrap_resp got s=%h id=%0d exp s=10000 id=2", resp_sum, resp_id);
      end
      @(negedge clk);
      total++; if (op_count !== 16'h0000) begin bad++; $display("FAIL wrap_count got %h exp 0000", op_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_carry();
      test_async_reset();
      test_fairness();
      test_backpressure();
      test_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
